// File: rtl/qblock_pkg.sv
// rtl/qblock_pkg.sv - shared types, encodings and bump table for the question block sprite
package qblock_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_BUMP   = 2'd1,
        ST_EMPTY  = 2'd2
    } qblock_state_e;

    localparam int SPRITE_W_DEF = 20;
    localparam int SPRITE_H_DEF = 20;

    localparam logic [1:0] FRAME_Q0    = 2'd0;
    localparam logic [1:0] FRAME_Q1    = 2'd1;
    localparam logic [1:0] FRAME_Q2    = 2'd2;
    localparam logic [1:0] FRAME_EMPTY = 2'd3;

    // Upward pixel shift of the block while it is bouncing, indexed by bump step.
    function automatic logic [9:0] bump_offset(input logic [2:0] idx);
        logic [9:0] off;
        case (idx)
            3'd0:    off = 10'd0;
            3'd1:    off = 10'd2;
            3'd2:    off = 10'd4;
            3'd3:    off = 10'd6;
            3'd4:    off = 10'd6;
            3'd5:    off = 10'd4;
            3'd6:    off = 10'd2;
            default: off = 10'd0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/qblock_addr_gen.sv
// rtl/qblock_addr_gen.sv - combinational pixel-to-sprite-ROM address mapping
module qblock_addr_gen
    import qblock_pkg::*;
#(
    parameter int SPRITE_W = SPRITE_W_DEF,
    parameter int SPRITE_H = SPRITE_H_DEF
) (
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic [9:0] block_x,
    input  logic [9:0] block_y,
    input  logic [9:0] offset,
    output logic       in_block,
    output logic [8:0] read_address
);

    logic [9:0]  top;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [19:0] linear;

    // Pixels left of / above the sprite wrap to large values and fall outside the bounds test.
    always_comb begin
        top          = (offset > block_y) ? 10'd0 : (block_y - offset);
        dx           = draw_x - block_x;
        dy           = draw_y - top;
        in_block     = (32'(dx) < 32'(SPRITE_W)) && (32'(dy) < 32'(SPRITE_H));
        linear       = 20'(dy) * 20'(SPRITE_W) + 20'(dx);
        read_address = in_block ? linear[8:0] : 9'd0;
    end

endmodule

// File: rtl/qblock_sprite_ctrl.sv
// rtl/qblock_sprite_ctrl.sv - question block animation, hit/bump FSM and sprite address pipeline
module qblock_sprite_ctrl
    import qblock_pkg::*;
#(
    parameter int SPRITE_W    = SPRITE_W_DEF,
    parameter int SPRITE_H    = SPRITE_H_DEF,
    parameter int ANIM_PERIOD = 8,
    parameter int BUMP_LEN    = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       level_reset,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic [9:0] block_x,
    input  logic [9:0] block_y,
    output logic [8:0] read_address,
    output logic [1:0] frame_sel,
    output logic       in_block,
    output logic       coin_spawn,
    output logic       used
);

    localparam int AW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam int BW = (BUMP_LEN > 1) ? $clog2(BUMP_LEN) : 1;
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_PERIOD - 1);
    localparam logic [BW-1:0] BUMP_LAST = BW'(BUMP_LEN - 1);

    qblock_state_e   state_q, state_d;
    logic [AW-1:0]   anim_cnt_q, anim_cnt_d;
    logic [1:0]      anim_frame_q, anim_frame_d;
    logic [BW-1:0]   bump_cnt_q, bump_cnt_d;
    logic            coin_q, coin_d;
    logic [1:0]      frame_sel_q, frame_sel_d;
    logic            used_q, used_d;
    logic            in_block_q;
    logic [8:0]      read_address_q;

    logic [9:0]      offset;
    logic            in_block_c;
    logic [8:0]      read_address_c;

    always_comb begin
        state_d      = state_q;
        anim_cnt_d   = anim_cnt_q;
        anim_frame_d = anim_frame_q;
        bump_cnt_d   = bump_cnt_q;
        coin_d       = 1'b0;

        if (level_reset) begin
            state_d      = ST_ACTIVE;
            anim_cnt_d   = '0;
            anim_frame_d = FRAME_Q0;
            bump_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    // A hit takes precedence over an animation step in the same cycle.
                    if (hit) begin
                        state_d    = ST_BUMP;
                        bump_cnt_d = '0;
                        anim_cnt_d = '0;
                        coin_d     = 1'b1;
                    end else if (frame_tick) begin
                        if (anim_cnt_q == ANIM_LAST) begin
                            anim_cnt_d   = '0;
                            anim_frame_d = (anim_frame_q == FRAME_Q2) ? FRAME_Q0
                                                                      : anim_frame_q + 2'd1;
                        end else begin
                            anim_cnt_d = anim_cnt_q + 1'b1;
                        end
                    end
                end
                ST_BUMP: begin
                    if (frame_tick) begin
                        if (bump_cnt_q == BUMP_LAST) begin
                            state_d    = ST_EMPTY;
                            bump_cnt_d = '0;
                        end else begin
                            bump_cnt_d = bump_cnt_q + 1'b1;
                        end
                    end
                end
                ST_EMPTY: ;
                default: state_d = ST_ACTIVE;
            endcase
        end

        frame_sel_d = (state_d == ST_ACTIVE) ? anim_frame_d : FRAME_EMPTY;
        used_d      = (state_d != ST_ACTIVE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_ACTIVE;
            anim_cnt_q   <= '0;
            anim_frame_q <= FRAME_Q0;
            bump_cnt_q   <= '0;
            coin_q       <= 1'b0;
            frame_sel_q  <= FRAME_Q0;
            used_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            anim_cnt_q   <= anim_cnt_d;
            anim_frame_q <= anim_frame_d;
            bump_cnt_q   <= bump_cnt_d;
            coin_q       <= coin_d;
            frame_sel_q  <= frame_sel_d;
            used_q       <= used_d;
        end
    end

    assign offset = (state_q == ST_BUMP) ? bump_offset(3'(bump_cnt_q)) : 10'd0;

    qblock_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_addr_gen (
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .block_x      (block_x),
        .block_y      (block_y),
        .offset       (offset),
        .in_block     (in_block_c),
        .read_address (read_address_c)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            in_block_q     <= 1'b0;
            read_address_q <= 9'd0;
        end else begin
            in_block_q     <= in_block_c;
            read_address_q <= read_address_c;
        end
    end

    assign read_address = read_address_q;
    assign in_block     = in_block_q;
    assign frame_sel    = frame_sel_q;
    assign coin_spawn   = coin_q;
    assign used         = used_q;

endmodule

// File: tb/tb_qblock_sprite_ctrl.sv
// tb/tb_qblock_sprite_ctrl.sv - randomized self-checking bench for qblock_sprite_ctrl
module tb_qblock_sprite_ctrl;

    localparam int SW = 20;
    localparam int SH = 20;
    localparam int ANIM_PERIOD = 8;
    localparam int BUMP_LEN = 8;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       hit = 1'b0;
    logic       level_reset = 1'b0;
    logic [9:0] draw_x = '0;
    logic [9:0] draw_y = '0;
    logic [9:0] block_x = '0;
    logic [9:0] block_y = '0;
    logic [8:0] read_address;
    logic [1:0] frame_sel;
    logic       in_block;
    logic       coin_spawn;
    logic       used;

    qblock_sprite_ctrl #(
        .SPRITE_W    (SW),
        .SPRITE_H    (SH),
        .ANIM_PERIOD (ANIM_PERIOD),
        .BUMP_LEN    (BUMP_LEN)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .hit          (hit),
        .level_reset  (level_reset),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .block_x      (block_x),
        .block_y      (block_y),
        .read_address (read_address),
        .frame_sel    (frame_sel),
        .in_block     (in_block),
        .coin_spawn   (coin_spawn),
        .used         (used)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 = unused block, 1 = bouncing, 2 = emptied.
    int m_state;
    int m_ticks;
    int m_bump;
    int bump_tbl [8] = '{0, 2, 4, 6, 6, 4, 2, 0};

    logic       exp_in;
    logic [8:0] exp_addr;
    logic [1:0] exp_fs;
    logic       exp_used;
    logic       exp_coin;

    task automatic model_reset();
        m_state = 0;
        m_ticks = 0;
        m_bump  = 0;
    endtask

    // Applies one cycle of inputs, advances the model, and returns after the edge (+1).
    task automatic step(input logic f, input logic h, input logic l,
                        input int dxv, input int dyv, input int bxv, input int byv);
        int off, top, ddx, ddy;
        frame_tick  = f;
        hit         = h;
        level_reset = l;
        draw_x      = 10'(dxv);
        draw_y      = 10'(dyv);
        block_x     = 10'(bxv);
        block_y     = 10'(byv);

        off = (m_state == 1) ? bump_tbl[m_bump] : 0;
        top = (off > byv) ? 0 : byv - off;
        ddx = (dxv - bxv) & 1023;
        ddy = (dyv - top) & 1023;
        exp_in   = (ddx < SW) && (ddy < SH);
        exp_addr = exp_in ? 9'(ddy * SW + ddx) : 9'd0;

        exp_coin = 1'b0;
        if (l) begin
            model_reset();
        end else if (m_state == 0 && h) begin
            m_state  = 1;
            m_bump   = 0;
            exp_coin = 1'b1;
        end else if (m_state == 0 && f) begin
            m_ticks++;
        end else if (m_state == 1 && f) begin
            m_bump++;
            if (m_bump == BUMP_LEN) begin
                m_state = 2;
                m_bump  = 0;
            end
        end
        exp_fs   = (m_state == 0) ? 2'((m_ticks / ANIM_PERIOD) % 3) : 2'd3;
        exp_used = (m_state != 0);

        @(posedge Clk);
        #1;
        frame_tick  = 1'b0;
        hit         = 1'b0;
        level_reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        n_vec++; if (read_address !== 9'd0) begin n_err++; $display("FAIL reset_addr got=%0d exp=0", read_address); end
        n_vec++; if (frame_sel !== 2'd0) begin n_err++; $display("FAIL reset_fs got=%0d exp=0", frame_sel); end
        n_vec++; if (in_block !== 1'b0) begin n_err++; $display("FAIL reset_in got=%b exp=0", in_block); end
        n_vec++; if (coin_spawn !== 1'b0) begin n_err++; $display("FAIL reset_coin got=%b exp=0", coin_spawn); end
        n_vec++; if (used !== 1'b0) begin n_err++; $display("FAIL reset_used got=%b exp=0", used); end
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_anim();
        for (int i = 1; i <= 24; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, 0, 100, 200);
            n_vec++; if (frame_sel !== exp_fs) begin n_err++; $display("FAIL anim_fs tick=%0d got=%0d exp=%0d", i, frame_sel, exp_fs); end
            n_vec++; if (used !== 1'b0) begin n_err++; $display("FAIL anim_used tick=%0d got=%b exp=0", i, used); end
            if (i == 8 || i == 16 || i == 24) begin
                n_vec++;
                if (frame_sel !== 2'(i / 8 % 3)) begin n_err++; $display("FAIL anim_boundary tick=%0d got=%0d exp=%0d", i, frame_sel, i / 8 % 3); end
            end
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0, 0, 0, 100, 200);
        end
    endtask

    task automatic test_addr();
        step(1'b0, 1'b0, 1'b0, 105, 203, 100, 200);
        n_vec++; if (in_block !== 1'b1 || read_address !== 9'd65) begin n_err++; $display("FAIL addr_inside got=%b/%0d exp=1/65", in_block, read_address); end
        step(1'b0, 1'b0, 1'b0, 120, 203, 100, 200);
        n_vec++; if (in_block !== 1'b0 || read_address !== 9'd0) begin n_err++; $display("FAIL addr_right_edge got=%b/%0d exp=0/0", in_block, read_address); end
        for (int i = 0; i < 60; i++) begin
            int bx, by;
            bx = $urandom_range(0, 1000);
            by = $urandom_range(0, 1000);
            step(1'b0, 1'b0, 1'b0, (bx + $urandom_range(0, 26) - 3) & 1023,
                 (by + $urandom_range(0, 26) - 3) & 1023, bx, by);
            n_vec++; if (in_block !== exp_in || read_address !== exp_addr) begin
                n_err++; $display("FAIL addr_rand got=%b/%0d exp=%b/%0d", in_block, read_address, exp_in, exp_addr);
            end
        end
    endtask

    task automatic test_hit();
        step(1'b0, 1'b1, 1'b0, 0, 0, 100, 200);
        n_vec++; if (coin_spawn !== 1'b1) begin n_err++; $display("FAIL hit_coin got=%b exp=1", coin_spawn); end
        n_vec++; if (frame_sel !== 2'd3 || used !== 1'b1) begin n_err++; $display("FAIL hit_state got=%0d/%b exp=3/1", frame_sel, used); end
        step(1'b0, 1'b0, 1'b0, 0, 0, 100, 200);
        n_vec++; if (coin_spawn !== 1'b0) begin n_err++; $display("FAIL hit_coin_width got=%b exp=0", coin_spawn); end
        step(1'b0, 1'b1, 1'b0, 0, 0, 100, 200);
        n_vec++; if (coin_spawn !== 1'b0) begin n_err++; $display("FAIL hit_in_bump got=%b exp=0", coin_spawn); end
        n_vec++; if (frame_sel !== exp_fs || used !== exp_used) begin n_err++; $display("FAIL hit_in_bump_state got=%0d/%b exp=%0d/%b", frame_sel, used, exp_fs, exp_used); end
    endtask

    task automatic test_bump_offset();
        step(1'b0, 1'b0, 1'b1, 0, 0, 100, 200);
        step(1'b0, 1'b1, 1'b0, 0, 0, 100, 200);
        repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0, 100, 200);
        step(1'b0, 1'b0, 1'b0, 100, 194, 100, 200);
        n_vec++; if (in_block !== 1'b1 || read_address !== 9'd0) begin n_err++; $display("FAIL bump_lift got=%b/%0d exp=1/0", in_block, read_address); end
        repeat (5) step(1'b1, 1'b0, 1'b0, 0, 0, 100, 200);
        step(1'b0, 1'b0, 1'b0, 100, 194, 100, 200);
        n_vec++; if (in_block !== 1'b0) begin n_err++; $display("FAIL empty_no_lift got=%b exp=0", in_block); end
        n_vec++; if (frame_sel !== 2'd3 || used !== 1'b1) begin n_err++; $display("FAIL empty_state got=%0d/%b exp=3/1", frame_sel, used); end
        step(1'b0, 1'b1, 1'b0, 0, 0, 100, 200);
        n_vec++; if (coin_spawn !== 1'b0) begin n_err++; $display("FAIL hit_in_empty got=%b exp=0", coin_spawn); end
    endtask

    task automatic test_priority();
        step(1'b0, 1'b0, 1'b1, 0, 0, 100, 200);
        step(1'b1, 1'b1, 1'b1, 0, 0, 100, 200);
        n_vec++; if (coin_spawn !== 1'b0) begin n_err++; $display("FAIL prio_coin got=%b exp=0", coin_spawn); end
        n_vec++; if (frame_sel !== 2'd0 || used !== 1'b0) begin n_err++; $display("FAIL prio_state got=%0d/%b exp=0/0", frame_sel, used); end
        step(1'b0, 1'b0, 1'b0, 0, 0, 100, 200);
        n_vec++; if (coin_spawn !== 1'b0) begin n_err++; $display("FAIL prio_coin_late got=%b exp=0", coin_spawn); end
    endtask

    task automatic test_reset_mid_bump();
        step(1'b0, 1'b1, 1'b0, 105, 203, 100, 200);
        step(1'b1, 1'b0, 1'b0, 105, 203, 100, 200);
        step(1'b1, 1'b0, 1'b0, 105, 203, 100, 200);
        #2;
        Reset_n = 1'b0;
        #1;
        n_vec++; if (read_address !== 9'd0 || in_block !== 1'b0 || frame_sel !== 2'd0 || coin_spawn !== 1'b0 || used !== 1'b0) begin
            n_err++; $display("FAIL async_reset got=%0d/%b/%0d/%b/%b exp=all 0", read_address, in_block, frame_sel, coin_spawn, used);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 0, 0, 100, 200);
        n_vec++; if (coin_spawn !== 1'b0 || frame_sel !== 2'd0 || used !== 1'b0) begin
            n_err++; $display("FAIL post_reset got=%b/%0d/%b exp=0/0/0", coin_spawn, frame_sel, used);
        end
        step(1'b0, 1'b1, 1'b0, 0, 0, 100, 200);
        n_vec++; if (coin_spawn !== 1'b1) begin n_err++; $display("FAIL rehit_coin got=%b exp=1", coin_spawn); end
    endtask

    task automatic test_random();
        step(1'b0, 1'b0, 1'b1, 0, 0, 100, 200);
        for (int i = 0; i < 400; i++) begin
            int bx, by;
            bx = $urandom_range(0, 60);
            by = $urandom_range(0, 12);
            step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 3,
                 bx + $urandom_range(0, 24) - 2, $urandom_range(0, 40), bx, by);
            n_vec++; if (in_block !== exp_in || read_address !== exp_addr) begin
                n_err++; $display("FAIL rand_addr i=%0d got=%b/%0d exp=%b/%0d", i, in_block, read_address, exp_in, exp_addr);
            end
            n_vec++; if (frame_sel !== exp_fs || used !== exp_used) begin
                n_err++; $display("FAIL rand_state i=%0d got=%0d/%b exp=%0d/%b", i, frame_sel, used, exp_fs, exp_used);
            end
            n_vec++; if (coin_spawn !== exp_coin) begin
                n_err++; $display("FAIL rand_coin i=%0d got=%b exp=%b", i, coin_spawn, exp_coin);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_anim();
        test_addr();
        test_hit();
        test_bump_offset();
        test_priority();
        test_reset_mid_bump();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qblock_sprite_ctrl.md
QBLOCK_SPRITE_CTRL -- requirements
Module: qblock_sprite_ctrl

Interface
REQ-001 SHALL have parameter SPRITE_W, default 20, meaning sprite width in pixels.
REQ-002 SHALL have parameter SPRITE_H, default 20, meaning sprite height in pixels.
REQ-003 SHALL have parameter ANIM_PERIOD, default 8, meaning frame_ticks per animation frame.
REQ-004 SHALL have parameter BUMP_LEN, default 8, meaning frame_ticks in the bump sequence.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; no other clock or reset exists.
REQ-006 Port: Clk  input  1  system clock; all state on rising edge.
REQ-007 Port: Reset_n  input  1  asynchronous active-low reset.
REQ-008 Port: frame_tick  input  1  one-cycle pulse per video frame (vsync).
REQ-009 Port: hit  input  1  one-cycle pulse, player head struck block.
REQ-010 Port: level_reset  input  1  synchronous pulse, restore block to unused.
REQ-011 Port: draw_x, draw_y  input  10 each  current pixel coordinate.
REQ-012 Port: block_x, block_y  input  10 each  block top-left at rest.
REQ-013 Port: read_address  output  9  sprite ROM address (0..399).
REQ-014 Port: frame_sel  output  2  0/1/2 = animated question frames, 3 = empty-block ROM.
REQ-015 Port: in_block  output  1  pixel lies inside the drawn block.
REQ-016 Port: coin_spawn  output  1  one-cycle pulse on accepted hit.
REQ-017 Port: used  output  1  block has been hit (BUMP or EMPTY).

Function
REQ-018 States SHALL be ACTIVE, BUMP, EMPTY.
REQ-019 ACTIVE: anim_cnt increments per frame_tick; at ANIM_PERIOD-1 wraps to 0 and anim_frame advances 0->1->2->0.
REQ-020 ACTIVE with hit: next state BUMP, bump_cnt=0, anim_cnt=0, coin_spawn=1 for exactly the next cycle.
REQ-021 hit coincident with frame_tick in ACTIVE: hit wins, no animation advance.
REQ-022 BUMP: bump_cnt increments per frame_tick; frame_tick with bump_cnt==BUMP_LEN-1 -> EMPTY, bump_cnt=0.
REQ-023 hit SHALL be ignored in BUMP and EMPTY (no coin_spawn, no state change).
REQ-024 level_reset SHALL have highest priority: next state ACTIVE, all counters 0, anim_frame 0, coin_spawn 0, regardless of hit/frame_tick.
REQ-025 frame_sel = anim_frame in ACTIVE, 3 in BUMP and EMPTY; used = 1 in BUMP and EMPTY.
REQ-026 Bump offset: BUMP uses table indexed by bump_cnt {0,2,4,6,6,4,2,0}; ACTIVE/EMPTY offset 0.
REQ-027 top = block_y - offset, clamped to 0 if offset > block_y.
REQ-028 dx = draw_x - block_x, dy = draw_y - top, 10-bit unsigned wraparound; in_block = (dx < SPRITE_W) and (dy < SPRITE_H).
REQ-029 read_address = dy*SPRITE_W + dx when in_block, else 0; product computed at ≥9 bits without truncation of valid values (max 399).
REQ-030 read_address and in_block SHALL be registered: one-cycle latency from draw_x/draw_y.
REQ-031 frame_sel, used registered from state; change one cycle after the causing event.

Reset
REQ-032 Reset_n low SHALL asynchronously force: state ACTIVE, anim_cnt/anim_frame/bump_cnt 0, read_address 0, frame_sel 0, in_block 0, coin_spawn 0, used 0.
REQ-033 Reset assertion mid-BUMP SHALL abort bump with no further coin_spawn after release.

Structure
REQ-034 Package qblock_pkg SHALL hold state enum, SPRITE_W/SPRITE_H defaults, frame_sel encodings (FRAME_EMPTY=3), bump offset table.
REQ-035 Pixel-to-address math SHALL be one sub-module qblock_addr_gen (combinational; registering in parent).

Verification
REQ-036 Reset then 24 frame_ticks, no hit -> frame_sel sequence 0,1,2,0 changing every 8 ticks; used=0.
REQ-037 block=(100,200), draw=(105,203) in ACTIVE -> next cycle in_block=1, read_address=65; draw=(120,203) -> in_block=0, read_address=0.
REQ-038 hit in ACTIVE -> coin_spawn high exactly 1 cycle, frame_sel=3, used=1; second hit during BUMP -> no coin_spawn.
REQ-039 BUMP bump_cnt=3, block=(100,200), draw=(100,194) -> in_block=1, read_address=0; after 8 frame_ticks state EMPTY, draw=(100,194) -> in_block=0.
REQ-040 hit, frame_tick, level_reset same cycle -> state ACTIVE, coin_spawn never asserted, frame_sel=0, used=0.
REQ-041 Reset_n pulsed low mid-BUMP -> all outputs 0 immediately, ACTIVE after release, block hittable again.
